// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing: frame-buffer request counters plus a LAT-deep
// sync/blank delay line that keeps the pins aligned with the pixel source.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int LAT      = 1,
   parameter int CW       = 10
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [23:0]   vga_data,
   output logic [CW-1:0] h_addr,
   output logic [CW-1:0] v_addr,
   output logic          req,
   output logic          frame_start,
   output logic          hsync,
   output logic          vsync,
   output logic          valid,
   output logic [7:0]    vga_r,
   output logic [7:0]    vga_g,
   output logic [7:0]    vga_b
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (LAT < 0 || LAT > 4) begin : g_bad_lat
         $fatal(1, "vga_timing_gen: LAT must lie in 0..4");
      end
      if (CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
         $fatal(1, "vga_timing_gen: CW cannot hold H_TOTAL-1 / V_TOTAL-1");
      end
      if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1 ||
          H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_geom
         $fatal(1, "vga_timing_gen: illegal timing geometry");
      end
   endgenerate

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_W  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_W  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [2:0]    IDLE     = {~HS_POL, ~VS_POL, 1'b0};

   logic          run_reg;
   logic [CW-1:0] h_cnt_reg, h_cnt_next;
   logic [CW-1:0] v_cnt_reg, v_cnt_next;

   always_comb begin
      h_cnt_next = h_cnt_reg;
      v_cnt_next = v_cnt_reg;
      if (run_reg) begin
         if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + CW'(1);
         end else begin
            h_cnt_next = h_cnt_reg + CW'(1);
         end
      end
   end

   // Counters only start advancing one edge after run rises, so (0,0) lasts a full clk.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         run_reg   <= 1'b0;
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         run_reg   <= 1'b1;
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   logic       hs_raw, vs_raw;
   logic [2:0] raw, dly;

   assign req         = run_reg & (h_cnt_reg < H_ACT_W) & (v_cnt_reg < V_ACT_W);
   assign h_addr      = req ? h_cnt_reg : '0;
   assign v_addr      = req ? v_cnt_reg : '0;
   assign frame_start = run_reg & (h_cnt_reg == '0) & (v_cnt_reg == '0);
   assign hs_raw      = (run_reg && h_cnt_reg >= HS_FIRST && h_cnt_reg <= HS_LAST) ? HS_POL : ~HS_POL;
   assign vs_raw      = (run_reg && v_cnt_reg >= VS_FIRST && v_cnt_reg <= VS_LAST) ? VS_POL : ~VS_POL;
   assign raw         = {hs_raw, vs_raw, req};

   generate
      if (LAT == 0) begin : g_comb
         assign dly = raw;
      end else begin : g_pipe
         logic [2:0] stage_reg [LAT];

         always_ff @(posedge clk) begin
            if (!resetn) begin
               for (int k = 0; k < LAT; k++) stage_reg[k] <= IDLE;
            end else begin
               stage_reg[0] <= raw;
               for (int k = 1; k < LAT; k++) stage_reg[k] <= stage_reg[k-1];
            end
         end

         assign dly = stage_reg[LAT-1];
      end
   endgenerate

   assign hsync = dly[2];
   assign vsync = dly[1];
   assign valid = dly[0];
   assign vga_r = valid ? vga_data[23:16] : 8'h00;
   assign vga_g = valid ? vga_data[15:8]  : 8'h00;
   assign vga_b = valid ? vga_data[7:0]   : 8'h00;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA controller. It generates programmable H/V timing with selectable sync polarity, drives pixel-request addresses to the frame-buffer, and delays sync/blank by a parameter LAT. LAT matches the read latency of the pixel source, so registered or BRAM-backed video memories stay aligned. It sits between the video memory and the VGA pins in top; VGA_CLK stays tied to clk.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clks)
H_SYNC, 96, hsync width (clks)
H_BP, 48, horizontal back porch (clks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level
LAT, 1, pixel-source read latency in clks, legal 0..4
CW, 10, counter/address width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
vga_data  in  24  {R,G,B} pixel, valid LAT clks after matching h_addr/v_addr
h_addr  out  CW  requested pixel column, 0 when req=0
v_addr  out  CW  requested pixel row, 0 when req=0
req  out  1  high when h_addr/v_addr name a visible pixel
frame_start  out  1  1-clk pulse at h_cnt=0, v_cnt=0 (request side, undelayed)
hsync  out  1  horizontal sync, delayed LAT clks
vsync  out  1  vertical sync, delayed LAT clks
valid  out  1  blank_n, delayed LAT clks
vga_r  out  8  vga_data[23:16] when valid, else 0
vga_g  out  8  vga_data[15:8] when valid, else 0
vga_b  out  8  vga_data[7:0] when valid, else 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 800x525, so 420000 clks per frame.
- Line order counted from 0: active, front porch, sync, back porch. The same order applies vertically, in lines.
- run flag: cleared by reset, set on first edge where resetn=1. While run=0, h_cnt and v_cnt hold 0 and req and frame_start are 0.
- When run=1, h_cnt increments every clk. At h_cnt=H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps to 0 at V_TOTAL-1 when h also wraps.
- req = run & (h_cnt<H_ACTIVE) & (v_cnt<V_ACTIVE). h_addr and v_addr are combinational from the counters.
- hs_raw = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. vs_raw is defined the same way on v_cnt, for the whole line.
- Delay pipeline: LAT register stages carry {hs_raw, vs_raw, req} to {hsync, vsync, valid}. LAT=0 means a pure combinational pass.
- RGB are combinational from vga_data gated by the delayed valid. A pixel requested at clk t appears on the pins at clk t+LAT.
- Reset (any time, including mid-line or mid-frame): at the next edge with resetn=0, counters go to 0, run goes to 0, and all pipeline stages load {~HS_POL, ~VS_POL, 0}.
- During and after reset, outputs are: hsync=~HS_POL, vsync=~VS_POL, valid=0, RGB=0, req=0, addresses=0, frame_start=0. When LAT=0 these values hold combinationally while run=0.
- First frame_start occurs in the first clk after resetn is sampled high.
- No state beyond counters, run and the delay pipeline. Parameter legality is checked at elaboration; an illegal LAT or CW is a fatal error.

Test Plan:
- Reset/startup, defaults: hold resetn=0 for 5 clks, then release.
  -> During reset: hsync=1, vsync=1, valid=0, RGB=0, req=0.
  -> frame_start pulses on clk 1 after release, then every 420000 clks.
- Horizontal timing, defaults, LAT=1: within one line, req is high for h_cnt 0..639.
  -> valid is high 640 clks, starting 1 clk after req rises.
  -> hsync is low exactly 96 clks, falling 657 clks after line start (656+LAT).
- Vertical timing, small set (H 4/1/1/1, V 3/1/1/1, LAT=0): H_TOTAL=7, V_TOTAL=6.
  -> frame_start period is 42 clks.
  -> vsync=0 for lines 4 only (7 clks); valid is high 12 clks per frame.
- Latency alignment, LAT=2: vga_data model returns {h_addr[7:0], v_addr[7:0], 8'hA5} with 2-clk delay.
  -> Every valid clk shows vga_r/vga_g equal to the address requested 2 clks earlier.
  -> vga_b=8'hA5, and RGB=0 whenever valid=0.
- Polarity, HS_POL=1, VS_POL=1: hsync and vsync are 0 at idle and during reset, and high only in their sync windows.
- Mid-operation reset: assert resetn=0 for 1 clk at h_cnt=300, v_cnt=200, LAT=3.
  -> Next clk: valid=0 and hsync/vsync are at idle levels.
  -> After release, frame_start pulses and the first visible pixel (0,0) appears 3 clks later.
